// File: rtl/sha1_pkg.sv
// Shared SHA-1 constants, FSM state type and context type.
package sha1_pkg;

   localparam logic [159:0] SHA1_IV =
      160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;

   localparam logic [31:0] K0 = 32'h5A827999;
   localparam logic [31:0] K1 = 32'h6ED9EBA1;
   localparam logic [31:0] K2 = 32'h8F1BBCDC;
   localparam logic [31:0] K3 = 32'hCA62C1D6;

   typedef enum logic [1:0] {FILL, START, WAIT, OUT} state_t;

   typedef logic [159:0] sha1_ctx_t;

   // Final message word: keep bytes 0..n-1, put the 0x80 marker in byte n, zero the rest.
   function automatic logic [31:0] pad_last_word(input logic [31:0] data, input logic [2:0] n);
      logic [31:0] w;
      w = '0;
      for (int b = 0; b < 4; b++) begin
         if (b < int'(n))
            w[31-8*b -: 8] = data[31-8*b -: 8];
         else if (b == int'(n))
            w[31-8*b -: 8] = 8'h80;
      end
      return w;
   endfunction

   // Byte counts above four are treated as a full word.
   function automatic logic [2:0] clamp_bytes(input logic [2:0] n);
      return (n > 3'd4) ? 3'd4 : n;
   endfunction

endpackage

// File: rtl/sha1_stream_if.sv
// Word-stream input and digest output handshakes of the SHA-1 streamer.
interface sha1_stream_if;
   logic         in_valid;
   logic         in_ready;
   logic [31:0]  in_data;
   logic         in_last;
   logic [2:0]   in_bytes;
   logic         digest_valid;
   logic         digest_ready;
   logic [159:0] digest;

   modport master (
      output in_valid, in_data, in_last, in_bytes, digest_ready,
      input  in_ready, digest_valid, digest
   );

   modport slave (
      input  in_valid, in_data, in_last, in_bytes, digest_ready,
      output in_ready, digest_valid, digest
   );
endinterface

// File: rtl/sha1_block.sv
// One SHA-1 compression per start: one round per clock, done pulses 80 cycles after the load edge.
module sha1_block
   import sha1_pkg::*;
(
   input  logic         clk,
   input  logic         start,
   input  sha1_ctx_t    context_in,
   input  logic [511:0] block,
   output logic         done,
   output sha1_ctx_t    context_out
);

   logic [31:0] a, b, c, d, e;
   logic [31:0] w [16];
   logic [6:0]  round;
   logic        running;
   logic [31:0] f, k, temp, w_new, w_mix;

   // Round function, constant, and next schedule word for the current round.
   always_comb begin
      f = b ^ c ^ d;
      k = K3;
      if (round < 7'd20) begin
         f = (b & c) | (~b & d);
         k = K0;
      end else if (round < 7'd40) begin
         k = K1;
      end else if (round < 7'd60) begin
         f = (b & c) | (b & d) | (c & d);
         k = K2;
      end
      temp  = {a[26:0], a[31:27]} + f + e + k + w[0];
      w_mix = w[13] ^ w[8] ^ w[2] ^ w[0];
      w_new = {w_mix[30:0], w_mix[31]};
   end

   // Load on start, then run 80 rounds over a sliding 16-word schedule window.
   always_ff @(posedge clk) begin
      done <= 1'b0;
      if (start) begin
         {a, b, c, d, e} <= context_in;
         for (int i = 0; i < 16; i++)
            w[i] <= block[511-32*i -: 32];
         round   <= '0;
         running <= 1'b1;
      end else if (running) begin
         a <= temp;
         b <= a;
         c <= {b[1:0], b[31:2]};
         d <= c;
         e <= d;
         for (int i = 0; i < 15; i++)
            w[i] <= w[i+1];
         w[15] <= w_new;
         round <= round + 7'd1;
         if (round == 7'd79) begin
            running <= 1'b0;
            done    <= 1'b1;
         end
      end
   end

   assign context_out = {context_in[159:128] + a, context_in[127:96] + b,
                         context_in[95:64] + c, context_in[63:32] + d,
                         context_in[31:0] + e};

endmodule

// File: rtl/sha1_stream.sv
// Streams big-endian words into 512-bit blocks, pads the message, chains sha1_block, and hands out the digest.
module sha1_stream
   import sha1_pkg::*;
#(
   parameter int LEN_W = 64
)
(
   input  logic clk,
   input  logic rst_n,
   sha1_stream_if.slave bus,
   output logic busy
);

   localparam int CNT_W = LEN_W - 3;

   state_t           state, state_next;
   sha1_ctx_t        h, ctx_out;
   logic [31:0]      buffer [16];
   logic [511:0]     block_flat;
   logic [3:0]       word_idx;
   logic [CNT_W-1:0] byte_cnt, byte_cnt_next;
   logic             final_blk, len_pending, pad80_pending;
   logic             start, done, accept;
   logic [2:0]       n, inc;
   logic [4:0]       p, word_idx_ext;
   logic [63:0]      len_new, len_old;

   sha1_block u_block (
      .clk         (clk),
      .start       (start),
      .context_in  (h),
      .block       (block_flat),
      .done        (done),
      .context_out (ctx_out)
   );

   // Derived handshake, padding position and message bit lengths.
   always_comb begin
      accept        = bus.in_valid & bus.in_ready;
      n             = clamp_bytes(bus.in_bytes);
      inc           = bus.in_last ? n : 3'd4;
      byte_cnt_next = byte_cnt + CNT_W'(inc);
      word_idx_ext  = {1'b0, word_idx};
      p             = word_idx_ext + ((n == 3'd4) ? 5'd1 : 5'd0);
      len_new       = '0;
      len_new[LEN_W-1:0] = {byte_cnt_next, 3'b000};
      len_old       = '0;
      len_old[LEN_W-1:0] = {byte_cnt, 3'b000};
      block_flat    = '0;
      for (int i = 0; i < 16; i++)
         block_flat[511-32*i -: 32] = buffer[i];
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= FILL;
      else
         state <= state_next;
   end

   // Next-state logic.
   always_comb begin
      state_next = state;
      case (state)
         FILL:  if (accept && (bus.in_last || word_idx == 4'd15)) state_next = START;
         START: state_next = WAIT;
         WAIT:  if (done) begin
                   if (final_blk)        state_next = OUT;
                   else if (len_pending) state_next = START;
                   else                  state_next = FILL;
                end
         OUT:   if (bus.digest_ready) state_next = FILL;
         default: state_next = FILL;
      endcase
   end

   // State-decoded outputs.
   always_comb begin
      bus.in_ready     = (state == FILL);
      bus.digest_valid = (state == OUT);
      start            = (state == START);
      busy             = (state != FILL);
   end

   assign bus.digest = h;

   // Buffer fill, padding, hash chaining and message bookkeeping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h             <= SHA1_IV;
         word_idx      <= '0;
         byte_cnt      <= '0;
         final_blk     <= 1'b0;
         len_pending   <= 1'b0;
         pad80_pending <= 1'b0;
         for (int i = 0; i < 16; i++)
            buffer[i] <= '0;
      end else begin
         case (state)
            FILL: if (accept) begin
               byte_cnt <= byte_cnt_next;
               if (!bus.in_last) begin
                  buffer[word_idx] <= bus.in_data;
                  if (word_idx != 4'd15)
                     word_idx <= word_idx + 4'd1;
               end else begin
                  for (int i = 0; i < 16; i++) begin
                     if (5'(i) == word_idx_ext)
                        buffer[i] <= pad_last_word(bus.in_data, n);
                     else if (5'(i) > word_idx_ext) begin
                        if (5'(i) == p)
                           buffer[i] <= 32'h8000_0000;
                        else if (p <= 5'd13 && i == 14)
                           buffer[i] <= len_new[63:32];
                        else if (p <= 5'd13 && i == 15)
                           buffer[i] <= len_new[31:0];
                        else
                           buffer[i] <= '0;
                     end
                  end
                  if (p <= 5'd13)
                     final_blk <= 1'b1;
                  else begin
                     len_pending <= 1'b1;
                     if (p == 5'd16)
                        pad80_pending <= 1'b1;
                  end
               end
            end
            WAIT: if (done) begin
               h <= ctx_out;
               if (!final_blk && len_pending) begin
                  for (int i = 0; i < 16; i++)
                     buffer[i] <= '0;
                  buffer[0]     <= pad80_pending ? 32'h8000_0000 : 32'h0;
                  buffer[14]    <= len_old[63:32];
                  buffer[15]    <= len_old[31:0];
                  len_pending   <= 1'b0;
                  pad80_pending <= 1'b0;
                  final_blk     <= 1'b1;
               end else if (!final_blk)
                  word_idx <= '0;
            end
            OUT: if (bus.digest_ready) begin
               h         <= SHA1_IV;
               byte_cnt  <= '0;
               word_idx  <= '0;
               final_blk <= 1'b0;
               for (int i = 0; i < 16; i++)
                  buffer[i] <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sha1_stream.sv
// Directed and randomized checks of sha1_stream against a whole-message SHA-1 model.
module tb_sha1_stream;
   import sha1_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   logic busy;

   sha1_stream_if bus();

   sha1_stream #(.LEN_W(64)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   int compare_count = 0;
   int fail_count    = 0;
   byte unsigned msg[$];

   localparam logic [159:0] REF_IV = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;

   task automatic checkOutput(input string tag, input logic [159:0] observed, input logic [159:0] expected);
      compare_count++;
      assert (observed === expected) else begin
         fail_count++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic reportTimeout(input string tag);
      compare_count++;
      fail_count++;
      $error("[TB] FAIL %s observed=timeout expected=event", tag);
   endtask

   function automatic logic [31:0] rotl(input logic [31:0] x, input int s);
      return (x << s) | (x >> (32 - s));
   endfunction

   // Textbook SHA-1 over a whole byte message.
   function automatic logic [159:0] ref_sha1(input byte unsigned m[$]);
      byte unsigned pm[$];
      logic [63:0] bit_len;
      logic [31:0] hh [5];
      logic [31:0] w [80];
      logic [31:0] a, b, c, d, e, f, k, t;
      int base;
      pm = m;
      bit_len = 64'(m.size()) * 64'd8;
      pm.push_back(8'h80);
      while (pm.size() % 64 != 56) pm.push_back(8'h00);
      for (int i = 7; i >= 0; i--) pm.push_back(bit_len[8*i +: 8]);
      hh[0] = 32'h67452301; hh[1] = 32'hEFCDAB89; hh[2] = 32'h98BADCFE;
      hh[3] = 32'h10325476; hh[4] = 32'hC3D2E1F0;
      for (int blk = 0; blk < pm.size() / 64; blk++) begin
         base = blk * 64;
         for (int i = 0; i < 16; i++)
            w[i] = {pm[base+4*i], pm[base+4*i+1], pm[base+4*i+2], pm[base+4*i+3]};
         for (int i = 16; i < 80; i++)
            w[i] = rotl(w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16], 1);
         a = hh[0]; b = hh[1]; c = hh[2]; d = hh[3]; e = hh[4];
         for (int i = 0; i < 80; i++) begin
            if (i < 20)      begin f = (b & c) | (~b & d);          k = 32'h5A827999; end
            else if (i < 40) begin f = b ^ c ^ d;                   k = 32'h6ED9EBA1; end
            else if (i < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
            else             begin f = b ^ c ^ d;                   k = 32'hCA62C1D6; end
            t = rotl(a, 5) + f + e + k + w[i];
            e = d; d = c; c = rotl(b, 30); b = a; a = t;
         end
         hh[0] += a; hh[1] += b; hh[2] += c; hh[3] += d; hh[4] += e;
      end
      return {hh[0], hh[1], hh[2], hh[3], hh[4]};
   endfunction

   // Send msg as words with random gaps, collect the digest and the last-accept-to-valid latency.
   task automatic applyStimulus(input int max_gap, input int hold_cycles,
                                output logic [159:0] dig, output int latency);
      int nw, waited, stall, lat, bad_ready, bad_hold, idx, nbytes;
      logic [31:0] data;
      logic [159:0] first;
      logic last;
      dig = '0;
      latency = -1;
      nw = (msg.size() + 3) / 4;
      if (nw == 0) nw = 1;
      for (int wi = 0; wi < nw; wi++) begin
         repeat ($urandom_range(0, max_gap)) @(negedge clk);
         data = $urandom;
         for (int b = 0; b < 4; b++) begin
            idx = 4 * wi + b;
            if (idx < msg.size()) data[31-8*b -: 8] = msg[idx];
         end
         last = (wi == nw - 1);
         nbytes = msg.size() - 4 * (nw - 1);
         bus.in_valid = 1'b1;
         bus.in_data  = data;
         bus.in_last  = last;
         if (!last)            bus.in_bytes = 3'($urandom);
         else if (nbytes == 4) bus.in_bytes = 3'(4 + $urandom_range(0, 3));
         else                  bus.in_bytes = 3'(nbytes);
         waited = 0;
         while (bus.in_ready !== 1'b1) begin
            @(negedge clk);
            waited++;
            if (waited > 2000) begin
               reportTimeout("in_ready");
               bus.in_valid = 1'b0;
               return;
            end
         end
         @(posedge clk);
         @(negedge clk);
         bus.in_valid = 1'b0;
         if (!last && (wi % 16 == 15)) begin
            checkOutput("busy_during_block", busy, 1'b1);
            stall = 0;
            while (bus.in_ready === 1'b0 && stall < 2000) begin
               stall++;
               @(negedge clk);
            end
            checkOutput("block_stall", stall, 82);
         end
      end
      lat = 1;
      bad_ready = 0;
      while (bus.digest_valid !== 1'b1) begin
         if (bus.in_ready !== 1'b0) bad_ready++;
         @(negedge clk);
         lat++;
         if (lat > 4000) begin
            reportTimeout("digest_valid");
            return;
         end
      end
      latency = lat - 1;
      checkOutput("in_ready_low_while_busy", bad_ready, 0);
      first = bus.digest;
      if (hold_cycles > 0) begin
         bad_hold = 0;
         repeat (hold_cycles) begin
            @(negedge clk);
            if (bus.digest !== first || bus.digest_valid !== 1'b1 || bus.in_ready !== 1'b0)
               bad_hold++;
         end
         checkOutput("digest_hold_stable", bad_hold, 0);
      end
      dig = bus.digest;
      bus.digest_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.digest_ready = 1'b0;
      checkOutput("in_ready_after_out", bus.in_ready, 1'b1);
      checkOutput("valid_drop_after_out", bus.digest_valid, 1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [159:0] dig;
      int lat, nw, blocks, len;
      string s;
      int lens [13];

      bus.in_valid     = 1'b0;
      bus.in_data      = '0;
      bus.in_last      = 1'b0;
      bus.in_bytes     = '0;
      bus.digest_ready = 1'b0;

      #2 rst_n = 1'b0;
      #1;
      checkOutput("reset_in_ready", bus.in_ready, 1'b1);
      checkOutput("reset_digest_valid", bus.digest_valid, 1'b0);
      checkOutput("reset_busy", busy, 1'b0);
      checkOutput("reset_digest_iv", bus.digest, REF_IV);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      $display("[TB] abc with held digest_ready");
      msg = '{8'h61, 8'h62, 8'h63};
      applyStimulus(0, 20, dig, lat);
      checkOutput("abc_digest", dig, 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d);
      checkOutput("abc_latency", lat, 82);

      applyStimulus(0, 0, dig, lat);
      checkOutput("abc_again_digest", dig, 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d);

      $display("[TB] empty message");
      msg.delete();
      applyStimulus(0, 0, dig, lat);
      checkOutput("empty_digest", dig, 160'hda39a3ee_5e6b4b0d_3255bfef_95601890_afd80709);
      checkOutput("empty_latency", lat, 82);

      $display("[TB] 56-byte message");
      s = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
      msg.delete();
      for (int i = 0; i < s.len(); i++) msg.push_back(s[i]);
      applyStimulus(0, 0, dig, lat);
      checkOutput("len56_digest", dig, 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1);
      checkOutput("len56_latency", lat, 164);

      $display("[TB] random messages");
      lens = '{52, 55, 56, 60, 63, 64, 65, 119, 128, 200, 0, 0, 0};
      for (int j = 10; j < 13; j++) lens[j] = $urandom_range(1, 300);
      foreach (lens[j]) begin
         len = lens[j];
         msg.delete();
         for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
         applyStimulus(3, $urandom_range(0, 3), dig, lat);
         checkOutput($sformatf("rand_len%0d_digest", len), dig, ref_sha1(msg));
         nw = (len + 3) / 4;
         if (nw == 0) nw = 1;
         blocks = (len + 8) / 64 + 1;
         checkOutput($sformatf("rand_len%0d_latency", len), lat, 82 * (blocks - (nw - 1) / 16));
      end

      $display("[TB] reset during compression");
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h61626300;
      bus.in_last  = 1'b1;
      bus.in_bytes = 3'd3;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (30) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("midwait_reset_in_ready", bus.in_ready, 1'b1);
      checkOutput("midwait_reset_busy", busy, 1'b0);
      checkOutput("midwait_reset_valid", bus.digest_valid, 1'b0);
      checkOutput("midwait_reset_digest", bus.digest, REF_IV);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      msg = '{8'h61, 8'h62, 8'h63};
      applyStimulus(0, 0, dig, lat);
      checkOutput("post_reset_abc_digest", dig, ref_sha1(msg));
      checkOutput("post_reset_abc_latency", lat, 82);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
      $finish;
   end

endmodule
